// File: rtl/maxpooling_stream_ctrl.sv
// ============================================================================
//  Module   : maxpooling_stream_ctrl
//  Brief    : Frame sequencer feeding the maxpooling datapath from a sync-read
//             buffer and checking the pooled output count.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module maxpooling_stream_ctrl #(
  parameter int CH      = 5,
  parameter int H       = 28,
  parameter int W       = 28,
  parameter int DW      = 16,
  parameter int AW      = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [9:0]    out_count,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          ena,
  output logic          frame_start_in,
  output logic          line_start_in,
  output logic          frame_end_in,
  output logic [DW-1:0] sig_layer,
  input  logic          valid,
  input  logic          frame_end_out
);

  localparam int UW       = (CH > 1) ? $clog2(CH) : 1;
  localparam int IW       = (H > 1) ? $clog2(H) : 1;
  localparam int JW       = (W > 1) ? $clog2(W) : 1;
  localparam int TW       = $clog2(TIMEOUT + 1);
  localparam int EXPECTED = CH * (H / 2) * (W / 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SOF    = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT1  = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    r_state;
  logic [UW-1:0] r_u;
  logic [IW-1:0] r_i;
  logic [JW-1:0] r_j;
  logic [AW-1:0] r_addr;
  logic [TW-1:0] r_timer;
  logic          r_err;
  logic [9:0]    r_count;
  logic          r_ena;
  logic          r_fs;
  logic          r_ls;
  logic          r_fe;

  logic          w_issue;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_last_map;
  logic          w_final;
  logic          w_count_en;
  logic [9:0]    w_count_next;
  logic          w_feo;
  logic          w_timeout;
  logic          w_mismatch;

  assign w_issue      = (r_state == S_STREAM) && !hold;
  assign w_last_col   = (r_j == JW'(W - 1));
  assign w_last_row   = (r_i == IW'(H - 1));
  assign w_last_map   = (r_u == UW'(CH - 1));
  assign w_final      = w_last_col && w_last_row && w_last_map;
  assign w_count_en   = valid && (r_state != S_IDLE) && (r_count != 10'h3FF);
  assign w_count_next = w_count_en ? r_count + 10'd1 : r_count;
  assign w_feo        = (r_state == S_DRAIN) && frame_end_out;
  assign w_timeout    = (r_state == S_DRAIN) && (r_timer == TW'(TIMEOUT));
  // Compare against the count including a valid coincident with frame_end_out.
  assign w_mismatch   = (w_count_next != 10'(EXPECTED));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_u     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_addr  <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
      r_ena   <= 1'b0;
      r_fs    <= 1'b0;
      r_ls    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      // Output stage: tag of the issued read, aligned with returning data.
      r_ena   <= w_issue;
      r_fs    <= 1'b0;
      r_ls    <= w_issue && w_last_col && !w_final;
      r_fe    <= w_issue && w_final;
      r_count <= w_count_next;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SOF;
            r_count <= '0;
            r_err   <= 1'b0;
            r_u     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_addr  <= '0;
          end
        end
        S_SOF: begin
          if (!hold) begin
            r_fs    <= 1'b1;
            r_ls    <= 1'b1;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_issue) begin
            r_addr <= r_addr + 1'b1;
            if (w_last_col) begin
              r_j <= '0;
              if (w_last_row) begin
                r_i <= '0;
                r_u <= w_last_map ? '0 : r_u + 1'b1;
              end else begin
                r_i <= r_i + 1'b1;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
            if (w_final) begin
              r_state <= S_WAIT1;
            end
          end
        end
        S_WAIT1: begin
          r_timer <= '0;
          r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_timer <= r_timer + 1'b1;
          // Error is folded in on the way into DONE so it is visible with done.
          if (w_feo) begin
            r_state <= S_DONE;
            r_err   <= r_err | w_mismatch;
          end else if (w_timeout) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign err            = r_err;
  assign out_count      = r_count;
  assign mem_rd_en      = w_issue;
  assign mem_rd_addr    = r_addr;
  assign ena            = r_ena;
  assign frame_start_in = r_fs;
  assign line_start_in  = r_ls;
  assign frame_end_in   = r_fe;
  assign sig_layer      = mem_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_maxpooling_stream_ctrl.sv
// ============================================================================
//  Module   : tb_maxpooling_stream_ctrl
//  Brief    : Scoreboard bench for maxpooling_stream_ctrl with buffer and pool models.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_maxpooling_stream_ctrl;

  localparam int CH      = 5;
  localparam int H       = 28;
  localparam int W       = 28;
  localparam int DW      = 16;
  localparam int AW      = 12;
  localparam int TIMEOUT = 1024;
  localparam int NWORDS  = CH * H * W;
  localparam int NPOOL   = CH * (H / 2) * (W / 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          hold;
  logic          busy;
  logic          done;
  logic          err;
  logic [9:0]    out_count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          ena;
  logic          frame_start_in;
  logic          line_start_in;
  logic          frame_end_in;
  logic [DW-1:0] sig_layer;
  logic          valid;
  logic          frame_end_out;

  maxpooling_stream_ctrl #(
    .CH(CH), .H(H), .W(W), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy), .done(done), .err(err), .out_count(out_count),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .ena(ena), .frame_start_in(frame_start_in), .line_start_in(line_start_in),
    .frame_end_in(frame_end_in), .sig_layer(sig_layer),
    .valid(valid), .frame_end_out(frame_end_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ramp(input int a);
    return DW'(a * 7 + 3);
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ramp(int'(mem_rd_addr));
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ls;
    logic          fe;
  } word_t;

  word_t exp_q[$];
  int cyc = 0;
  int m_u, m_i, m_j;
  int n_ena, n_ls, n_fe, n_fs, fs_cyc, fe_cyc, first_ena_cyc, s_cyc;
  bit fe_seen;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected words on ena, pushes expected words on each issued read.
  always @(negedge clk) begin
    word_t w;
    int    a;
    if (!rst) begin
      if (ena) begin
        if (n_ena == 0) first_ena_cyc = cyc;
        n_ena++;
        if (line_start_in) n_ls++;
        if (exp_q.size() == 0) begin
          check("ena_without_read", exp_q.size(), 1);
        end else begin
          w = exp_q.pop_front();
          check("sig_layer", 32'(sig_layer), 32'(w.data));
          check("line_start_in", 32'(line_start_in), 32'(w.ls));
          check("frame_end_in", 32'(frame_end_in), 32'(w.fe));
          check("frame_start_on_ena", 32'(frame_start_in), 0);
        end
      end
      if (frame_end_in) begin
        n_fe++;
        fe_seen = 1'b1;
        fe_cyc  = cyc;
      end
      if (frame_start_in) begin
        n_fs++;
        fs_cyc = cyc;
        check("sof_line_start", 32'(line_start_in), 1);
        check("sof_ena", 32'(ena), 0);
      end
      if (mem_rd_en) begin
        a = m_u * H * W + m_i * W + m_j;
        check("rd_addr", 32'(mem_rd_addr), a);
        w.data = ramp(a);
        w.fe   = (m_u == CH - 1) && (m_i == H - 1) && (m_j == W - 1);
        w.ls   = (m_j == W - 1) && !w.fe;
        exp_q.push_back(w);
        if (m_j == W - 1) begin
          m_j = 0;
          if (m_i == H - 1) begin m_i = 0; m_u++; end
          else m_i++;
        end else begin
          m_j++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    exp_q.delete();
    m_u = 0; m_i = 0; m_j = 0;
    n_ena = 0; n_ls = 0; n_fe = 0; n_fs = 0;
    fe_seen = 1'b0;
    start = 1'b1;
    s_cyc = cyc;
    tick();
    start = 1'b0;
    check("sof_busy", 32'(busy), 1);
    check("start_clears_err", 32'(err), 0);
    check("start_clears_count", 32'(out_count), 0);
  endtask

  task automatic stream_to_end(input bit do_hold);
    bit held = 1'b0;
    int k = 0;
    int n0;
    while (!fe_seen && k < NWORDS + 200) begin
      if (do_hold && !held && mem_rd_addr == AW'(1777)) begin
        held = 1'b1;
        n0   = n_ena;
        hold = 1'b1;
        for (int h = 0; h < 5; h++) begin
          check("hold_addr_frozen", 32'(mem_rd_addr), 1777);
          #1;
          check("hold_no_read", 32'(mem_rd_en), 0);
          tick();
        end
        hold = 1'b0;
        check("hold_inflight_words", n_ena - n0, 1);
      end
      tick();
      k++;
    end
    if (!fe_seen) check("frame_end_in_seen", 32'(fe_seen), 1);
    if (do_hold) check("hold_point_reached", 32'(held), 1);
  endtask

  task automatic drain(input int nvalid, input bit send_feo, output int done_cyc);
    int k = 0;
    for (int v = 0; v < nvalid; v++) begin
      valid         = 1'b1;
      frame_end_out = send_feo && (v == nvalid - 1);
      tick();
    end
    valid         = 1'b0;
    frame_end_out = 1'b0;
    while (!done && k < TIMEOUT + 50) begin
      tick();
      k++;
    end
    check("done_seen", 32'(done), 1);
    done_cyc = cyc;
  endtask

  task automatic check_frame(input int exp_count, input bit exp_err);
    check("err_at_done", 32'(err), 32'(exp_err));
    check("out_count_at_done", 32'(out_count), exp_count);
    check("ena_cycles", n_ena, NWORDS);
    check("line_start_pulses", n_ls, CH * H - 1);
    check("frame_end_pulses", n_fe, 1);
    check("frame_start_pulses", n_fs, 1);
    check("frame_start_latency", fs_cyc - s_cyc, 2);
    check("first_ena_latency", first_ena_cyc - s_cyc, 3);
    check("scoreboard_empty", exp_q.size(), 0);
    tick();
    check("done_one_cycle", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
    check("err_sticky", 32'(err), 32'(exp_err));
  endtask

  initial begin
    int dc;
    int a;
    int k;
    bit saw_done;
    rst = 1'b1; start = 1'b0; hold = 1'b0; valid = 1'b0; frame_end_out = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 0);
    check("rst_mem_rd_addr", 32'(mem_rd_addr), 0);
    check("rst_ena", 32'(ena), 0);
    check("rst_flags", {29'd0, frame_start_in, line_start_in, frame_end_in}, 0);
    rst = 1'b0;
    tick();

    // Nominal frame with a pool returning the full result count.
    start_frame();
    stream_to_end(1'b0);
    drain(NPOOL, 1'b1, dc);
    check_frame(NPOOL, 1'b0);

    // Mid-stream stall at u=2,i=7,j=13.
    start_frame();
    stream_to_end(1'b1);
    drain(NPOOL, 1'b1, dc);
    check_frame(NPOOL, 1'b0);

    // Pool never ends the frame.
    start_frame();
    stream_to_end(1'b0);
    drain(NPOOL, 1'b0, dc);
    check("timeout_latency", dc - fe_cyc, TIMEOUT + 2);
    check_frame(NPOOL, 1'b1);

    // One result short.
    start_frame();
    stream_to_end(1'b0);
    drain(NPOOL - 1, 1'b1, dc);
    check_frame(NPOOL - 1, 1'b1);

    // Restart clears err; extra start ignored; async reset mid-stream.
    start_frame();
    k = 0;
    while (mem_rd_addr < AW'(100) && k < 500) begin
      tick();
      k++;
    end
    valid = 1'b1;
    repeat (3) tick();
    valid = 1'b0;
    a = int'(mem_rd_addr);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("extra_start_busy", 32'(busy), 1);
    check("extra_start_addr", 32'(mem_rd_addr), a + 1);
    check("extra_start_count", 32'(out_count), 3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_count", 32'(out_count), 0);
    check("async_rst_rd_en", 32'(mem_rd_en), 0);
    check("async_rst_addr", 32'(mem_rd_addr), 0);
    check("async_rst_ena", 32'(ena), 0);
    check("async_rst_flags", {29'd0, frame_start_in, line_start_in, frame_end_in}, 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    check("no_done_after_rst", 32'(saw_done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
